// File: rtl/bram_toggle_pkg.sv
// -----------------------------------------------------------------------------
// bram_toggle_pkg
// Shared types and helpers for the bram_toggle_ctrl power-noise sequencer.
//   state_t  : sequencer states (IDLE, FILL, RUN_ON, RUN_OFF, DRAIN)
//   PAT_BASE : alternating 1010... base pattern, wide enough for any D_WID
//              up to PAT_MAX_W (callers take the low D_WID bits)
//   pat()    : max-toggle word for a given address LSB and pass bit; adjacent
//              words are complementary and every bit flips on each pass
// -----------------------------------------------------------------------------
package bram_toggle_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    RUN_ON  = 3'd2,
    RUN_OFF = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam int PAT_MAX_W = 64;

  // LSB-aligned, so the low 16 bits read 16'hAAAA
  localparam logic [PAT_MAX_W-1:0] PAT_BASE = {32{2'b10}};

  function automatic logic [PAT_MAX_W-1:0] pat(input logic addr_lsb, input logic pass);
    pat = PAT_BASE ^ {PAT_MAX_W{addr_lsb ^ pass}};
  endfunction

endpackage

// File: rtl/bram_toggle_chk.sv
// -----------------------------------------------------------------------------
// bram_toggle_chk
// Read-data checker for bram_toggle_ctrl. The identity of each issued read
// (valid, address LSB, pass bit) is delayed one cycle to line up with the
// bram's registered read data; the expected pattern is rebuilt from it and
// compared against dout. A mismatch sets the sticky err flag and bumps a
// saturating 16-bit counter on the following edge.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr          synchronous clear of err / err_cnt (accepted start)
//   rd_vld       a read is issued this cycle
//   rd_addr_lsb  LSB of the address being read
//   rd_pass      pass bit the read location is expected to hold
//   dout         bram read data (one cycle after the read)
//   err          sticky miscompare flag
//   err_cnt      saturating miscompare count
// -----------------------------------------------------------------------------
module bram_toggle_chk
  import bram_toggle_pkg::*;
#(
  parameter int D_WID = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             rd_vld,
  input  logic             rd_addr_lsb,
  input  logic             rd_pass,
  input  logic [D_WID-1:0] dout,
  output logic             err,
  output logic [15:0]      err_cnt
);

  logic             chk_vld_r;
  logic             chk_lsb_r;
  logic             chk_pass_r;
  logic [D_WID-1:0] exp_s;
  logic             miscmp_s;

  // Expected word for the read whose data is on dout now, and the compare
  always_comb begin
    exp_s    = D_WID'(pat(chk_lsb_r, chk_pass_r));
    miscmp_s = chk_vld_r && (dout != exp_s);
  end

  // One-cycle delay of the read identity to match the bram read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_vld_r  <= 1'b0;
      chk_lsb_r  <= 1'b0;
      chk_pass_r <= 1'b0;
    end else if (clr) begin
      chk_vld_r  <= 1'b0;
      chk_lsb_r  <= 1'b0;
      chk_pass_r <= 1'b0;
    end else begin
      chk_vld_r  <= rd_vld;
      chk_lsb_r  <= rd_addr_lsb;
      chk_pass_r <= rd_pass;
    end
  end

  // Sticky error flag and saturating miscompare counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= 16'h0000;
    end else if (clr) begin
      err     <= 1'b0;
      err_cnt <= 16'h0000;
    end else if (miscmp_s) begin
      err <= 1'b1;
      if (err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end else begin
        err_cnt <= err_cnt;
      end
    end else begin
      err     <= err;
      err_cnt <= err_cnt;
    end
  end

endmodule

// File: rtl/bram_toggle_ctrl.sv
// -----------------------------------------------------------------------------
// bram_toggle_ctrl
// Sequencer for one simple-dual-port bram in the power-noise array. It fills
// the memory with a max-toggle pattern, then runs gated read-modify-write
// bursts (ON window of reads+writes every cycle, OFF window idle) to present a
// programmable square-wave current load. Read data is checked against the
// expected pattern so supply-droop corruption gets flagged.
//
// Build option: define BRAM_TOGGLE_CHK_EN to build the read-data checker
// (bram_toggle_chk). Without it dout is unused and err/err_cnt are tied 0;
// addressing, write data and timing are the same in both builds.
//
// Ports:
//   clk       single clock (bram wrclk/rdclk)
//   rst       asynchronous active-high reset
//   start     IDLE -> FILL (ignored outside IDLE, loses to stop)
//   stop      abort to DRAIN from any non-IDLE state
//   on_cyc    ON window length, sampled on every ON entry (0 acts as 1)
//   off_cyc   OFF window length, sampled on every OFF entry (0 = no OFF)
//   wraddr    bram write address
//   din       bram write data
//   we        bram write enable
//   porta_en  bram port A enable (mirrors we)
//   portb_en  bram port B read address register enable
//   rdaddr    bram read address
//   dout      bram read data, one cycle after rdaddr/portb_en
//   busy      high in every state except IDLE
//   run_on    high in RUN_ON (scope trigger marker)
//   err       sticky miscompare flag, cleared by start
//   err_cnt   saturating miscompare count, cleared by start
// -----------------------------------------------------------------------------
module bram_toggle_ctrl
  import bram_toggle_pkg::*;
#(
  parameter int A_WID   = 11,
  parameter int D_WID   = 16,
  parameter int CNT_WID = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_WID-1:0] on_cyc,
  input  logic [CNT_WID-1:0] off_cyc,
  output logic [A_WID-1:0]   wraddr,
  output logic [D_WID-1:0]   din,
  output logic               we,
  output logic               porta_en,
  output logic               portb_en,
  output logic [A_WID-1:0]   rdaddr,
  input  logic [D_WID-1:0]   dout,
  output logic               busy,
  output logic               run_on,
  output logic               err,
  output logic [15:0]        err_cnt
);

  localparam logic [A_WID-1:0]   ADDR_ZERO = {A_WID{1'b0}};
  localparam logic [A_WID-1:0]   ADDR_ONE  = {{(A_WID-1){1'b0}}, 1'b1};
  localparam logic [D_WID-1:0]   DATA_ZERO = {D_WID{1'b0}};
  localparam logic [CNT_WID-1:0] CNT_ZERO  = {CNT_WID{1'b0}};
  localparam logic [CNT_WID-1:0] CNT_ONE   = {{(CNT_WID-1){1'b0}}, 1'b1};

  state_t             state_r;
  // In FILL: address written this cycle. In RUN_ON: address read this cycle.
  // In RUN_OFF: next address to read when the burst resumes.
  logic [A_WID-1:0]   addr_r;
  logic               pass_r;
  logic [CNT_WID-1:0] win_cnt_r;

  logic [A_WID-1:0]   addr_inc_s;
  logic               addr_last_s;
  logic [CNT_WID-1:0] on_load_s;
  logic               start_ok_s;
  logic [D_WID-1:0]   fill_pat_s;
  logic [D_WID-1:0]   rmw_pat_s;

  // Next-address, window reload and pattern words used by the sequencer
  always_comb begin
    addr_inc_s  = addr_r + ADDR_ONE;
    addr_last_s = &addr_r;
    if (on_cyc == CNT_ZERO) begin
      on_load_s = CNT_ONE;
    end else begin
      on_load_s = on_cyc;
    end
    start_ok_s = (state_r == IDLE) && start && !stop;
    fill_pat_s = D_WID'(pat(addr_inc_s[0], 1'b0));
    // The read of addr_r this cycle becomes next cycle's write of the next pass
    rmw_pat_s  = D_WID'(pat(addr_r[0], ~pass_r));
  end

  // Sequencer FSM with registered bram controls and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      addr_r    <= ADDR_ZERO;
      pass_r    <= 1'b0;
      win_cnt_r <= CNT_ZERO;
      wraddr    <= ADDR_ZERO;
      din       <= DATA_ZERO;
      we        <= 1'b0;
      porta_en  <= 1'b0;
      portb_en  <= 1'b0;
      rdaddr    <= ADDR_ZERO;
      busy      <= 1'b0;
      run_on    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            state_r  <= FILL;
            addr_r   <= ADDR_ZERO;
            pass_r   <= 1'b0;
            wraddr   <= ADDR_ZERO;
            din      <= D_WID'(pat(1'b0, 1'b0));
            we       <= 1'b1;
            porta_en <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end

        FILL: begin
          if (stop) begin
            // Nothing is pending in FILL: the current write lands this edge
            state_r  <= DRAIN;
            we       <= 1'b0;
            porta_en <= 1'b0;
          end else if (addr_last_s) begin
            state_r   <= RUN_ON;
            addr_r    <= ADDR_ZERO;
            pass_r    <= 1'b0;
            we        <= 1'b0;
            porta_en  <= 1'b0;
            rdaddr    <= ADDR_ZERO;
            portb_en  <= 1'b1;
            run_on    <= 1'b1;
            win_cnt_r <= on_load_s;
          end else begin
            addr_r <= addr_inc_s;
            wraddr <= addr_inc_s;
            din    <= fill_pat_s;
          end
        end

        RUN_ON: begin
          // Write back the location read this cycle, in every exit path
          wraddr   <= addr_r;
          din      <= rmw_pat_s;
          we       <= 1'b1;
          porta_en <= 1'b1;
          addr_r   <= addr_inc_s;
          if (addr_last_s) begin
            pass_r <= ~pass_r;
          end else begin
            pass_r <= pass_r;
          end
          if (stop) begin
            state_r  <= DRAIN;
            portb_en <= 1'b0;
            run_on   <= 1'b0;
          end else if (win_cnt_r <= CNT_ONE) begin
            if (off_cyc == CNT_ZERO) begin
              // No OFF window: start the next burst back-to-back
              win_cnt_r <= on_load_s;
              rdaddr    <= addr_inc_s;
            end else begin
              state_r   <= RUN_OFF;
              win_cnt_r <= off_cyc;
              portb_en  <= 1'b0;
              run_on    <= 1'b0;
            end
          end else begin
            win_cnt_r <= win_cnt_r - CNT_ONE;
            rdaddr    <= addr_inc_s;
          end
        end

        RUN_OFF: begin
          // The trailing write completes in the first OFF cycle only
          we       <= 1'b0;
          porta_en <= 1'b0;
          if (stop) begin
            state_r <= DRAIN;
          end else if (win_cnt_r <= CNT_ONE) begin
            state_r   <= RUN_ON;
            win_cnt_r <= on_load_s;
            rdaddr    <= addr_r;
            portb_en  <= 1'b1;
            run_on    <= 1'b1;
          end else begin
            win_cnt_r <= win_cnt_r - CNT_ONE;
          end
        end

        DRAIN: begin
          state_r   <= IDLE;
          addr_r    <= ADDR_ZERO;
          pass_r    <= 1'b0;
          win_cnt_r <= CNT_ZERO;
          wraddr    <= ADDR_ZERO;
          din       <= DATA_ZERO;
          we        <= 1'b0;
          porta_en  <= 1'b0;
          portb_en  <= 1'b0;
          rdaddr    <= ADDR_ZERO;
          busy      <= 1'b0;
          run_on    <= 1'b0;
        end

        default: begin
          state_r   <= IDLE;
          addr_r    <= ADDR_ZERO;
          pass_r    <= 1'b0;
          win_cnt_r <= CNT_ZERO;
          wraddr    <= ADDR_ZERO;
          din       <= DATA_ZERO;
          we        <= 1'b0;
          porta_en  <= 1'b0;
          portb_en  <= 1'b0;
          rdaddr    <= ADDR_ZERO;
          busy      <= 1'b0;
          run_on    <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRAM_TOGGLE_CHK_EN
  // pass_r always describes the location on rdaddr while portb_en is high
  bram_toggle_chk #(
    .D_WID (D_WID)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .clr         (start_ok_s),
    .rd_vld      (portb_en),
    .rd_addr_lsb (rdaddr[0]),
    .rd_pass     (pass_r),
    .dout        (dout),
    .err         (err),
    .err_cnt     (err_cnt)
  );
`else
  logic unused_dout_s;
  assign unused_dout_s = ^dout;
  assign err           = 1'b0;
  assign err_cnt       = 16'h0000;
`endif

endmodule
